// File: rtl/water_flow_monitor.sv
// water_flow_monitor
// Watches the drum water level over fixed windows and raises a sticky fault
// when the level fails to move in the commanded direction (fill or drain) for
// MAX_STRIKES consecutive windows.
//
// Ports:
//   clk                 system clock, rising edge
//   reset               synchronous active-high reset
//   water_flow_reset    1 = monitor disabled and cleared, 0 = running
//   water_flow_mode     1 = filling, 0 = draining
//   water_level_sensor  current drum level (10 bits)
//   water_flow_error    registered sticky fault flag
//   fault_mode          mode latched at fault (1 = fill, 0 = drain)
//   monitor_active      1 while monitoring or faulted
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | disabled; waits for water_flow_reset = 0 to capture
// MONITOR | counting window cycles, evaluating progress per window
// FAULT   | fault raised; everything frozen until cleared
module water_flow_monitor #(
    parameter int WINDOW_CYCLES = 1000,
    parameter int MIN_DELTA     = 4,
    parameter int MAX_STRIKES   = 3,
    parameter int FULL_LEVEL    = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       water_flow_reset,
    input  logic       water_flow_mode,
    input  logic [9:0] water_level_sensor,
    output logic       water_flow_error,
    output logic       fault_mode,
    output logic       monitor_active
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MONITOR = 2'd1,
        FAULT   = 2'd2
    } state_t;

    localparam logic [15:0] WIN_LAST  = 16'(WINDOW_CYCLES - 1);
    localparam logic [10:0] DELTA_W   = 11'(MIN_DELTA);
    localparam logic [10:0] FULL_W    = 11'(FULL_LEVEL);
    localparam logic [3:0]  STRIKES_W = 4'(MAX_STRIKES);

    state_t      state_q, state_d;
    logic [9:0]  baseline_q, baseline_d;
    logic        mode_q, mode_d;
    logic [15:0] window_cnt_q, window_cnt_d;
    logic [3:0]  strikes_q, strikes_d;
    logic        error_q, error_d;
    logic        fault_mode_q, fault_mode_d;
    logic        active_q, active_d;

    // Progress terms use 11 bits so baseline + delta cannot wrap near full scale.
    logic [10:0] sensor_w, baseline_w;
    logic        fill_progress, drain_progress, progress;
    logic [3:0]  strikes_inc;

    always_comb begin
        sensor_w       = {1'b0, water_level_sensor};
        baseline_w     = {1'b0, baseline_q};
        fill_progress  = (sensor_w >= baseline_w + DELTA_W) || (sensor_w >= FULL_W);
        drain_progress = (sensor_w + DELTA_W <= baseline_w) || (water_level_sensor == 10'd0);
        progress       = mode_q ? fill_progress : drain_progress;
        strikes_inc    = strikes_q + 4'd1;
    end

    always_comb begin
        state_d      = state_q;
        baseline_d   = baseline_q;
        mode_d       = mode_q;
        window_cnt_d = window_cnt_q;
        strikes_d    = strikes_q;

        // Mode is only looked at when water_flow_reset is low, so an X on it
        // during reset never reaches a register.
        if (water_flow_reset) begin
            state_d      = IDLE;
            baseline_d   = '0;
            mode_d       = 1'b0;
            window_cnt_d = '0;
            strikes_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d      = MONITOR;
                    baseline_d   = water_level_sensor;
                    mode_d       = water_flow_mode;
                    window_cnt_d = '0;
                    strikes_d    = '0;
                end
                MONITOR: begin
                    if (water_flow_mode != mode_q) begin
                        // Direction changed: restart as a fresh capture.
                        baseline_d   = water_level_sensor;
                        mode_d       = water_flow_mode;
                        window_cnt_d = '0;
                        strikes_d    = '0;
                    end else if (window_cnt_q == WIN_LAST) begin
                        window_cnt_d = '0;
                        baseline_d   = water_level_sensor;
                        if (progress) begin
                            strikes_d = '0;
                        end else begin
                            strikes_d = strikes_inc;
                            if (strikes_inc == STRIKES_W) begin
                                state_d = FAULT;
                            end
                        end
                    end else begin
                        window_cnt_d = window_cnt_q + 16'd1;
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Outputs follow the next state so they change on the same edge.
        error_d      = (state_d == FAULT);
        fault_mode_d = (state_d == FAULT) ? mode_d : 1'b0;
        active_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            baseline_q   <= '0;
            mode_q       <= 1'b0;
            window_cnt_q <= '0;
            strikes_q    <= '0;
            error_q      <= 1'b0;
            fault_mode_q <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            baseline_q   <= baseline_d;
            mode_q       <= mode_d;
            window_cnt_q <= window_cnt_d;
            strikes_q    <= strikes_d;
            error_q      <= error_d;
            fault_mode_q <= fault_mode_d;
            active_q     <= active_d;
        end
    end

    assign water_flow_error = error_q;
    assign fault_mode       = fault_mode_q;
    assign monitor_active   = active_q;

endmodule

// File: tb/tb_water_flow_monitor.sv
module tb_water_flow_monitor;

    localparam int W    = 8;
    localparam int MD   = 4;
    localparam int MS   = 2;
    localparam int FULL = 1000;

    logic       clk;
    logic       reset;
    logic       wfr;
    logic       mode;
    logic [9:0] sensor;
    logic       err, fm, act;

    int checks = 0;
    int errors = 0;

    // Reference model: monitor described by capture time and window arithmetic.
    int edge_n = 0;
    int m_cap = 0;
    int m_base = 0;
    int m_strikes = 0;
    bit m_run = 0;
    bit m_fault = 0;
    bit m_mode = 0;
    bit m_fm = 0;

    water_flow_monitor #(
        .WINDOW_CYCLES(W), .MIN_DELTA(MD), .MAX_STRIKES(MS), .FULL_LEVEL(FULL)
    ) dut (
        .clk(clk), .reset(reset), .water_flow_reset(wfr), .water_flow_mode(mode),
        .water_level_sensor(sensor), .water_flow_error(err), .fault_mode(fm),
        .monitor_active(act)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_edge();
        int  s;
        bit  prog;
        edge_n++;
        s = int'(sensor);
        if (reset || wfr) begin
            m_run = 0; m_fault = 0; m_fm = 0; m_strikes = 0;
        end else if (!m_run || (!m_fault && mode != m_mode)) begin
            m_run = 1; m_cap = edge_n; m_base = s; m_mode = mode; m_strikes = 0;
        end else if (!m_fault && ((edge_n - m_cap) % W) == 0) begin
            if (m_mode) prog = (s >= m_base + MD) || (s >= FULL);
            else        prog = (s + MD <= m_base) || (s == 0);
            m_strikes = prog ? 0 : m_strikes + 1;
            m_base = s;
            if (m_strikes == MS) begin
                m_fault = 1; m_fm = m_mode;
            end
        end
    endtask

    // Advance one edge; inputs are already set, outputs are read 1 time unit later.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_then_start(input bit md, input logic [9:0] lvl);
        wfr = 1'b1; step();
        wfr = 1'b0; mode = md; sensor = lvl;
        step();   // capture edge
    endtask

    task automatic test_reset();
        reset = 1'b1; wfr = 1'b1; step();
        checks++;
        if ({err, fm, act} !== 3'b000) begin
            errors++;
            $display("FAIL reset_state got %b%b%b want 000", err, fm, act);
        end
        reset = 1'b0;
    endtask

    task automatic test_healthy_fill();
        wfr = 1'b0; mode = 1'b1; sensor = 10'd0;
        step();
        checks++;
        if (act !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL fill_capture act=%b err=%b want act=1 err=0", act, err);
        end
        for (int i = 0; i < 200; i++) begin
            sensor = sensor + 10'd1;
            step();
            if (err !== 1'b0 || act !== 1'b1 || err !== m_fault) begin
                errors++;
                $display("FAIL healthy_fill cycle %0d err=%b act=%b want err=0 act=1", i, err, act);
            end
        end
        checks++;
    endtask

    task automatic test_stalled(input bit md, input logic [9:0] lvl, input string tag);
        clear_then_start(md, lvl);
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 15) begin
                checks++;
                if (err !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_early edge %0d err=%b want 0", tag, k, err);
                end
            end
        end
        checks++;
        if (err !== 1'b1 || fm !== md || act !== 1'b1) begin
            errors++;
            $display("FAIL %s_fault err=%b fm=%b act=%b want 1 %b 1", tag, err, fm, act, md);
        end
        for (int i = 0; i < 20; i++) begin
            sensor = sensor + 10'd3;
            mode = ~mode;
            step();
        end
        checks++;
        if (err !== 1'b1 || fm !== md) begin
            errors++;
            $display("FAIL %s_hold err=%b fm=%b want 1 %b", tag, err, fm, md);
        end
    endtask

    task automatic test_no_fault(input bit md, input logic [9:0] lvl, input string tag);
        clear_then_start(md, lvl);
        for (int i = 0; i < 100; i++) begin
            step();
            if (err !== 1'b0 || act !== 1'b1) begin
                errors++;
                $display("FAIL %s cycle %0d err=%b act=%b want err=0 act=1", tag, i, err, act);
                break;
            end
        end
        checks++;
    endtask

    task automatic test_strike_reset();
        clear_then_start(1'b1, 10'd50);
        for (int k = 1; k <= 32; k++) begin
            if (k == 12) sensor = 10'd60;
            step();
            if (k < 32 && err !== 1'b0) begin
                errors++;
                $display("FAIL strike_reset_early edge %0d err=%b want 0", k, err);
            end
        end
        checks++;
        checks++;
        if (err !== 1'b1 || fm !== 1'b1) begin
            errors++;
            $display("FAIL strike_reset_fault err=%b fm=%b want 1 1", err, fm);
        end
    endtask

    task automatic test_mode_flip();
        clear_then_start(1'b1, 10'd50);
        for (int k = 1; k <= 28; k++) begin
            if (k == 12) mode = 1'b0;
            step();
            if (k < 28 && err !== 1'b0) begin
                errors++;
                $display("FAIL mode_flip_early edge %0d err=%b want 0", k, err);
            end
        end
        checks++;
        checks++;
        if (err !== 1'b1 || fm !== 1'b0) begin
            errors++;
            $display("FAIL mode_flip_fault err=%b fm=%b want 1 0", err, fm);
        end
    endtask

    task automatic test_clear_rearm();
        clear_then_start(1'b1, 10'd50);
        repeat (16) step();
        wfr = 1'b1; step();
        checks++;
        if ({err, fm, act} !== 3'b000) begin
            errors++;
            $display("FAIL clear_edge got %b%b%b want 000", err, fm, act);
        end
        wfr = 1'b0; step();
        checks++;
        if (act !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL rearm_capture act=%b err=%b want 1 0", act, err);
        end
        repeat (15) step();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL rearm_early err=%b want 0", err);
        end
        step();
        checks++;
        if (err !== 1'b1 || fm !== 1'b1) begin
            errors++;
            $display("FAIL rearm_fault err=%b fm=%b want 1 1", err, fm);
        end
    endtask

    task automatic test_reset_mid();
        clear_then_start(1'b1, 10'd50);
        repeat (4) step();
        reset = 1'b1; step();
        checks++;
        if ({err, fm, act} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid got %b%b%b want 000", err, fm, act);
        end
        reset = 1'b0; step();
        checks++;
        if (act !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_recapture act=%b want 1", act);
        end
    endtask

    task automatic test_random();
        int lvl;
        int bad = 0;
        lvl = 500;
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            wfr   = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 59) == 0) mode = ~mode;
            if (wfr) mode = 1'($urandom);
            case ($urandom_range(0, 9))
                0: lvl = 0;
                1: lvl = 1023 - $urandom_range(0, 3);
                2: lvl = 996 + $urandom_range(0, 8);
                default: lvl = lvl + $urandom_range(0, 2) - 1 + (mode ? $urandom_range(0, 1) : -$urandom_range(0, 1));
            endcase
            if (lvl < 0) lvl = 0;
            if (lvl > 1023) lvl = 1023;
            sensor = 10'(lvl);
            step();
            checks++;
            if ({err, fm, act} !== {m_fault, m_fm, m_run}) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL random edge %0d got err/fm/act=%b%b%b want %b%b%b",
                             edge_n, err, fm, act, m_fault, m_fm, m_run);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wfr = 1'b1; mode = 1'b0; sensor = 10'd0;
        test_reset();
        test_healthy_fill();
        test_stalled(1'b1, 10'd50, "stalled_fill");
        test_stalled(1'b0, 10'd50, "stalled_drain");
        test_no_fault(1'b0, 10'd0, "drain_empty");
        test_no_fault(1'b1, 10'd1000, "fill_full");
        test_strike_reset();
        test_mode_flip();
        test_clear_rearm();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/water_flow_monitor.md
# water_flow_monitor

Supervises the water flow to and from the drum. It watches `water_level_sensor` over fixed time windows and raises `water_flow_error` when the level stops moving in the expected direction for too many consecutive windows. It sits directly upstream of the washing-machine control FSM. The FSM drives `water_flow_mode` and `water_flow_reset` into this block and consumes `water_flow_error`, classifying a fault as a fill fault or a drainage fault.

## Interface
- `WINDOW_CYCLES`, default 1000: length of one evaluation window in clock cycles; legal range 1..65535.
- `MIN_DELTA`, default 4: minimum level change per window that counts as progress; legal range 1..1023.
- `MAX_STRIKES`, default 3: number of consecutive failing windows that raises a fault; legal range 1..15.
- `FULL_LEVEL`, default 1000: sensor level at or above which filling is treated as complete (no fill fault possible).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  reset; one clock; reset is synchronous and active-high.
- `water_flow_reset`  in  1  1 = monitor disabled and cleared; 0 = monitor running.
- `water_flow_mode`  in  1  1 = filling, 0 = draining; sampled only while `water_flow_reset` = 0.
- `water_level_sensor`  in  10  current drum water level.
- `water_flow_error`  out  1  registered, sticky fault flag.
- `fault_mode`  out  1  mode latched at fault (1 = fill fault, 0 = drain fault); valid only while `water_flow_error` = 1.
- `monitor_active`  out  1  1 while in MONITOR or FAULT.

## Operation
- Internal state:
  - `baseline`, 10 bits.
  - `mode_q`, 1 bit.
  - `window_cnt`, 16 bits.
  - `strikes`, 4 bits.
  - `state`: IDLE, MONITOR or FAULT.
- IDLE:
  - Outputs are 0.
  - On an edge with `water_flow_reset` = 0: `baseline` := sensor, `mode_q` := `water_flow_mode`, `window_cnt` := 0, `strikes` := 0, go to MONITOR. This edge is the capture edge.
- MONITOR, every edge:
  - `window_cnt` increments.
  - On the edge where `window_cnt` = `WINDOW_CYCLES`-1, evaluate the window.
- Window evaluation, using 11-bit unsigned arithmetic with no wrap:
  - Fill progress = (sensor >= `baseline` + `MIN_DELTA`) OR (sensor >= `FULL_LEVEL`).
  - Drain progress = (sensor + `MIN_DELTA` <= `baseline`) OR (sensor == 0).
  - If there is progress, `strikes` := 0; otherwise `strikes` := `strikes`+1.
  - Then `baseline` := sensor and `window_cnt` := 0.
  - If the incremented `strikes` equals `MAX_STRIKES`, go to FAULT.
- Mode change in MONITOR (`water_flow_mode` != `mode_q` with `water_flow_reset` = 0):
  - Restart exactly as the IDLE capture: new baseline, new mode, counters cleared.
  - Takes priority over window evaluation on the same edge.
- FAULT:
  - `water_flow_error` = 1 and `fault_mode` = `mode_q`, both held.
  - Counters frozen.
  - Sensor and mode changes are ignored.
- Priority, highest first:
  1. `reset`
  2. `water_flow_reset`
  3. Mode change
  4. Window evaluation
- `water_flow_reset` = 1 in any state: go to IDLE and clear all registers and outputs on that edge.

## Timing
- Reset values: `water_flow_error` = 0, `fault_mode` = 0, `monitor_active` = 0, state IDLE, all counters and `baseline` = 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Window evaluations occur `WINDOW_CYCLES` edges after the capture edge, and every `WINDOW_CYCLES` edges after that.
- Worst-case fault latency with a stalled level: `water_flow_error` rises on the edge `MAX_STRIKES`×`WINDOW_CYCLES` edges after the capture edge.
- `monitor_active` rises on the capture edge.
- Clearing: `water_flow_error` falls on the first edge at which `water_flow_reset` or `reset` is 1.
- Re-arm: after `water_flow_reset` returns to 0, the next edge is a new capture edge.
- `water_flow_mode` may be X while `water_flow_reset` = 1. It must not propagate into any register in that case.
- `reset` mid-window: full clear on that edge, identical to the power-up state.

## Test plan
Parameters for all scenarios: `WINDOW_CYCLES`=8, `MIN_DELTA`=4, `MAX_STRIKES`=2, `FULL_LEVEL`=1000.
- Healthy fill: reset → release `water_flow_reset`, mode=1, sensor ramps +1 per cycle from 0 for 200 cycles → `water_flow_error` stays 0; `monitor_active`=1 from the capture edge.
- Stalled fill: mode=1, sensor constant 50 → `water_flow_error`=1 and `fault_mode`=1 exactly 16 edges after the capture edge; both held while the sensor later ramps.
- Drain cases:
  - Mode=0, sensor constant 50 → error at capture+16 with `fault_mode`=0.
  - Mode=0, sensor constant 0 → no error after 100 cycles.
  - Mode=1, sensor constant 1000 → no error after 100 cycles.
- Strike reset: mode=1, sensor held 50 for window 1, stepped to 60 during window 2, held 60 for windows 3 and 4 → no error at capture+16, error at capture+32.
- Mode flip restart: mode=1, sensor 50 constant; at capture+12 flip mode to 0 → strikes cleared; error with `fault_mode`=0 at (flip edge)+16, not earlier.
- Clear and re-arm:
  - In FAULT, pulse `water_flow_reset` for 1 cycle → error 0 on that edge; next edge recaptures; a stalled level faults again 16 edges later.
  - Asserting `reset` at capture+5 → all outputs 0 on that edge.
